// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: round-robin grant with optional burst lock, fixed-latency tagged return.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module sprite_rom_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 24,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 8
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_rd,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB, OWN} state_e;

  state_e                         state_q;
  logic [PW-1:0]                  ptr_q, owner_q;
  logic [7:0]                     burst_cnt_q;
  logic [RD_LAT:0]                vld_pipe_q;
  logic [RD_LAT:0][NUM_REQ-1:0]   tag_pipe_q;
  logic [ADDR_W-1:0]              rom_addr_q;
  logic [NUM_REQ-1:0]             rd_valid_q;
  logic [DATA_W-1:0]              rd_data_q;

  logic [PW-1:0] win, idx_w;
  logic          found;
  logic [8:0]    cnt_inc;
  logic          cap;
  int            idx;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ-1) ? '0 : i + PW'(1);
  endfunction

  // Search from ptr; in OWN only the owner is eligible.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_REQ;
      idx_w = PW'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
    if (state_q == OWN) begin
      win   = owner_q;
      found = req[owner_q];
    end
  end

  assign gnt     = (found && !Reset) ? (NUM_REQ'(1) << win) : '0;
  assign cnt_inc = {1'b0, burst_cnt_q} + 9'd1;
  assign cap     = cnt_inc >= 9'(BURST_MAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB: if (found) begin
          if (req_lock[win] && BURST_MAX > 1) begin
            state_q     <= OWN;
            owner_q     <= win;
            burst_cnt_q <= 8'd1;
          end else if (!FIXED_PRIO) begin
            ptr_q <= inc(win);
          end
        end
        OWN: begin
          if (found) burst_cnt_q <= cnt_inc[7:0];
          if (!found || !req_lock[owner_q] || cap) begin
            state_q <= ARB;
            if (!FIXED_PRIO) ptr_q <= inc(owner_q);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // Tag stage RD_LAT lines up with rom_data; its contents are registered onto the return port.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      rom_addr_q <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[RD_LAT-1:0], |gnt};
      tag_pipe_q <= {tag_pipe_q[RD_LAT-1:0], gnt};
      if (|gnt) rom_addr_q <= req_addr[win*ADDR_W +: ADDR_W];
      rd_valid_q <= vld_pipe_q[RD_LAT] ? tag_pipe_q[RD_LAT] : '0;
      if (vld_pipe_q[RD_LAT]) rd_data_q <= rom_data;
    end
  end

  assign rom_rd   = vld_pipe_q[0];
  assign rom_addr = rom_addr_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign busy     = |vld_pipe_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: directed scenarios plus random traffic against a scoreboard model.
module tb_sprite_rom_arbiter;
  localparam int N = 2, AW = 19, DW = 24, RL = 2, BM = 8;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic Clk = 1'b0, Reset;
  logic [N-1:0] req, req_lock, gnt, rd_valid;
  logic [N*AW-1:0] req_addr;
  logic rom_rd, busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, rd_data;

  always #5 Clk = ~Clk;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .BURST_MAX(BM)) dut (
    .Clk(Clk), .Reset(Reset), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy));

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = ({13'b0, a} * 32'd40503) ^ 32'h005A_5A5A;
    return t[DW-1:0];
  endfunction

  // ROM: data for the address strobed RL cycles earlier
  logic [AW-1:0] dly [RL];
  always @(posedge Clk) begin
    dly[0] <= rom_addr;
    for (int i = 1; i < RL; i++) dly[i] <= dly[i-1];
  end
  assign rom_data = rom_fn(dly[RL-1]);

  typedef struct { int gc; int tag; logic [AW-1:0] addr; } rd_t;
  rd_t pend[$];
  int checks = 0, errors = 0;
  int cyc = 0, m_ptr = 0, m_own = -1, m_cnt = 0;
  logic [AW-1:0] m_rom_addr = '0;
  logic [DW-1:0] m_rd_data = '0;
  logic [N-1:0] e_gnt, e_rd_valid;
  logic e_rom_rd, e_busy;
  logic [AW-1:0] e_rom_addr;

  function automatic logic [AW-1:0] addr_of(input int i);
    return req_addr[i*AW +: AW];
  endfunction

  task automatic eval();
    @(negedge Clk);
    e_gnt = '0;
    if (!Reset) begin
      if (m_own >= 0) begin
        if (req[m_own]) e_gnt[m_own] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr + k) % N;
          if (req[i]) begin e_gnt[i] = 1'b1; break; end
        end
      end
    end
    e_rom_rd   = pend.size() > 0 && pend[$].gc == cyc - 1;
    e_rom_addr = m_rom_addr;
    e_rd_valid = '0;
    if (pend.size() > 0 && pend[0].gc == cyc - RL - 2) begin
      e_rd_valid[pend[0].tag] = 1'b1;
      m_rd_data = rom_fn(pend[0].addr);
      void'(pend.pop_front());
    end
    e_busy = pend.size() > 0;
  endtask

  task automatic commit();
    int w;
    w = -1;
    for (int k = 0; k < N; k++) if (e_gnt[k]) w = k;
    if (Reset) begin
      pend.delete();
      m_ptr = 0; m_own = -1; m_cnt = 0;
      m_rom_addr = '0; m_rd_data = '0;
    end else begin
      if (w >= 0) begin
        rd_t r;
        r.gc = cyc; r.tag = w; r.addr = addr_of(w);
        pend.push_back(r);
        m_rom_addr = r.addr;
      end
      if (m_own >= 0) begin
        if (w >= 0) m_cnt++;
        if (w < 0 || !req_lock[m_own] || m_cnt >= BM) begin
          m_ptr = FIXED ? 0 : (m_own + 1) % N;
          m_own = -1;
        end
      end else if (w >= 0) begin
        if (req_lock[w] && BM > 1) begin m_own = w; m_cnt = 1; end
        else m_ptr = FIXED ? 0 : (w + 1) % N;
      end
    end
    @(posedge Clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    Reset = 1'b1; req = '0; req_lock = '0;
    eval(); commit();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; req = 2'b11; req_lock = '0; req_addr = {19'h1, 19'h2};
    eval(); commit();
    eval();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
    checks++; if (rom_rd !== 1'b0) begin errors++; $display("FAIL reset_rom_rd got=%b exp=0", rom_rd); end
    checks++; if (rom_addr !== '0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    checks++; if (rd_valid !== '0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    commit();
    Reset = 1'b0; req = '0;
  endtask

  task automatic test_single();
    req = 2'b01; req_addr = {19'h0, 19'h00123};
    eval();
    checks++; if (gnt !== 2'b01 || gnt !== e_gnt) begin errors++; $display("FAIL single_gnt got=%b exp=01", gnt); end
    commit();
    req = '0; req_addr = '0;
    for (int k = 1; k <= 5; k++) begin
      eval();
      checks++; if (rom_rd !== e_rom_rd) begin errors++; $display("FAIL single_rom_rd k=%0d got=%b exp=%b", k, rom_rd, e_rom_rd); end
      checks++; if (rd_valid !== e_rd_valid) begin errors++; $display("FAIL single_rd_valid k=%0d got=%b exp=%b", k, rd_valid, e_rd_valid); end
      if (k == 1) begin
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 19'h00123) begin errors++; $display("FAIL single_rom got=%b/%h exp=1/00123", rom_rd, rom_addr); end
      end
      if (k == 4) begin
        checks++; if (rd_valid !== 2'b01 || rd_data !== rom_fn(19'h00123)) begin errors++; $display("FAIL single_ret got=%b/%h exp=01/%h", rd_valid, rd_data, rom_fn(19'h00123)); end
      end
      commit();
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] gs [10], vs [10], ex [5];
    ex = FIXED ? '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10} : '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    do_reset();
    req_addr = {19'h2AAAA, 19'h15555};
    for (int i = 0; i < 10; i++) begin
      req = (i < 4) ? 2'b11 : (i < 5) ? 2'b10 : 2'b00;
      eval();
      gs[i] = gnt; vs[i] = rd_valid;
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL cont_gnt i=%0d got=%b exp=%b", i, gnt, e_gnt); end
      checks++; if (rd_data !== m_rd_data) begin errors++; $display("FAIL cont_rd_data i=%0d got=%h exp=%h", i, rd_data, m_rd_data); end
      commit();
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (gs[i] !== ex[i]) begin errors++; $display("FAIL cont_seq i=%0d got=%b exp=%b", i, gs[i], ex[i]); end
      checks++; if (vs[i+4] !== ex[i]) begin errors++; $display("FAIL cont_ret i=%0d got=%b exp=%b", i, vs[i+4], ex[i]); end
    end
  endtask

  task automatic test_burst();
    logic [N-1:0] ex;
    do_reset();
    req_addr = {19'h0ABCD, 19'h13579};
    for (int i = 0; i < 16; i++) begin
      req      = (i == 0) ? 2'b01 : (i <= 10) ? 2'b11 : 2'b00;
      req_lock = (i >= 1 && i <= 10) ? 2'b10 : 2'b00;
      eval();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL burst_gnt i=%0d got=%b exp=%b", i, gnt, e_gnt); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL burst_busy i=%0d got=%b exp=%b", i, busy, e_busy); end
      if (i <= 10) begin
        ex = (FIXED || i == 0 || i == 9) ? 2'b01 : 2'b10;
        checks++; if (gnt !== ex) begin errors++; $display("FAIL burst_seq i=%0d got=%b exp=%b", i, gnt, ex); end
      end
      commit();
    end
  endtask

  task automatic test_release();
    logic [N-1:0] ex;
    do_reset();
    req_addr = {19'h44444, 19'h33333};
    for (int i = 0; i < 12; i++) begin
      req      = (i <= 6) ? 2'b11 : 2'b00;
      if (i == 0) req = 2'b01;
      req_lock = (i >= 1 && i <= 3) ? 2'b10 : 2'b00;
      eval();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rel_gnt i=%0d got=%b exp=%b", i, gnt, e_gnt); end
      if (i <= 6) begin
        ex = (FIXED || i == 0 || i == 5) ? 2'b01 : 2'b10;
        checks++; if (gnt !== ex) begin errors++; $display("FAIL rel_seq i=%0d got=%b exp=%b", i, gnt, ex); end
      end
      commit();
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b01; req_lock = '0; req_addr = {19'h0, 19'h7ABCD};
    eval();
    checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rmid_gnt got=%b exp=%b", gnt, e_gnt); end
    commit();
    req = 2'b11; Reset = 1'b1;
    eval();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rmid_gnt_in_reset got=%b exp=00", gnt); end
    checks++; if (rom_rd !== 1'b1) begin errors++; $display("FAIL rmid_rom_rd got=%b exp=1", rom_rd); end
    commit();
    Reset = 1'b0; req = '0;
    for (int i = 0; i < 5; i++) begin
      eval();
      checks++; if (rd_valid !== 2'b00) begin errors++; $display("FAIL rmid_rd_valid i=%0d got=%b exp=00", i, rd_valid); end
      checks++; if (rom_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle i=%0d got=%b/%b exp=0/0", i, rom_rd, busy); end
      checks++; if (rom_addr !== '0 || rd_data !== '0) begin errors++; $display("FAIL rmid_regs i=%0d got=%h/%h exp=0/0", i, rom_addr, rd_data); end
      commit();
    end
    req = 2'b10; req_addr = {19'h1F00F, 19'h0};
    for (int i = 0; i < 6; i++) begin
      eval();
      checks++; if (gnt !== e_gnt || rd_valid !== e_rd_valid) begin errors++; $display("FAIL rmid_after i=%0d got=%b/%b exp=%b/%b", i, gnt, rd_valid, e_gnt, e_rd_valid); end
      if (i == 0) begin
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rmid_first got=%b exp=10", gnt); end
      end
      commit();
      req = '0;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r, g;
    logic [AW-1:0] a [N];
    do_reset();
    r = '0;
    for (int i = 0; i < N; i++) a[i] = AW'($urandom);
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i]) begin r[i] = $urandom_range(0, 2) != 0; a[i] = AW'($urandom); end
        req_lock[i] = $urandom_range(0, 3) != 0;
        req_addr[i*AW +: AW] = a[i];
      end
      req = (c < 690) ? r : '0;
      Reset = (c < 690) && ($urandom_range(0, 99) == 0);
      eval();
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, e_gnt); end
      checks++; if (rom_rd !== e_rom_rd) begin errors++; $display("FAIL rnd_rom_rd c=%0d got=%b exp=%b", c, rom_rd, e_rom_rd); end
      checks++; if (rom_addr !== e_rom_addr) begin errors++; $display("FAIL rnd_rom_addr c=%0d got=%h exp=%h", c, rom_addr, e_rom_addr); end
      checks++; if (rd_valid !== e_rd_valid) begin errors++; $display("FAIL rnd_rd_valid c=%0d got=%b exp=%b", c, rd_valid, e_rd_valid); end
      checks++; if (rd_data !== m_rd_data) begin errors++; $display("FAIL rnd_rd_data c=%0d got=%h exp=%h", c, rd_data, m_rd_data); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, e_busy); end
      g = e_gnt;
      commit();
      for (int i = 0; i < N; i++)
        if (g[i]) begin r[i] = $urandom_range(0, 3) != 0; a[i] = AW'($urandom); end
    end
    Reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_burst();
    test_release();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
